// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory write port and one read port among N ports;
// read returns are steered back to the issuing port through an in-order tag FIFO.

module mem_port_arb_core #(
   parameter int N        = 4,
   parameter int ARB_MODE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);
   localparam int PW = $clog2(N);
   logic [PW-1:0] ptr, ptr_nxt;
   logic [PW:0]   j;
   always_comb begin
      idx = ptr;
      any = 1'b0;
      j   = '0;
      if (ARB_MODE != 0) begin
         for (int i = 0; i < N; i++) begin
            j = {1'b0, ptr} + (PW+1)'(i);
            j = (j >= (PW+1)'(N)) ? j - (PW+1)'(N) : j;
            if (!any && req[j[PW-1:0]]) begin
               any = 1'b1;
               idx = j[PW-1:0];
            end
         end
      end else begin
         any = req[ptr];
      end
      gnt = N'(any) << idx;
      // TDM always advances; round-robin moves past the winner or holds
      ptr_nxt = (ARB_MODE != 0 && !any) ? ptr : (idx == PW'(N-1) ? '0 : idx + PW'(1));
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr_nxt;
endmodule

module mem_port_arbiter #(
   parameter int N          = 4,
   parameter int ADDR_W     = 10,
   parameter int BLOCK_BITS = 512,
   parameter int RD_DEPTH   = 4,
   parameter int ARB_MODE   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N-1:0]                  wr_req_i,
   input  logic [N*ADDR_W-1:0]           wr_addr_i,
   input  logic [N*BLOCK_BITS-1:0]       wr_data_i,
   output logic [N-1:0]                  wr_gnt_o,
   output logic                          mem_we_o,
   output logic [ADDR_W-1:0]             mem_waddr_o,
   output logic [BLOCK_BITS-1:0]         mem_wdata_o,
   input  logic [N-1:0]                  rd_req_i,
   input  logic [N*ADDR_W-1:0]           rd_addr_i,
   output logic [N-1:0]                  rd_gnt_o,
   output logic                          mem_re_o,
   output logic [ADDR_W-1:0]             mem_raddr_o,
   input  logic                          mem_rvalid_i,
   input  logic [BLOCK_BITS-1:0]         mem_rdata_i,
   output logic [N-1:0]                  rd_valid_o,
   output logic [BLOCK_BITS-1:0]         rd_data_o,
   output logic [$clog2(RD_DEPTH+1)-1:0] rd_outstanding_o,
   output logic                          rd_err_o
);
   localparam int PW = $clog2(N);
   localparam int CW = $clog2(RD_DEPTH+1);
   localparam int AW = RD_DEPTH > 1 ? $clog2(RD_DEPTH) : 1;
   logic [PW-1:0] widx, ridx;
   logic [PW-1:0] tag [RD_DEPTH];
   logic [AW-1:0] wp, rp;
   logic          pop, allow;
   mem_port_arb_core #(.N(N), .ARB_MODE(ARB_MODE)) u_wr (
      .clk(clk), .rst_n(rst_n), .req(wr_req_i), .gnt(wr_gnt_o), .idx(widx), .any(mem_we_o));
   assign mem_waddr_o = mem_we_o ? wr_addr_i[widx*ADDR_W +: ADDR_W] : '0;
   assign mem_wdata_o = mem_we_o ? wr_data_i[widx*BLOCK_BITS +: BLOCK_BITS] : '0;
   // a same-cycle pop frees a slot, so a full FIFO can still accept an issue
   assign pop   = mem_rvalid_i && rd_outstanding_o != '0;
   assign allow = rd_outstanding_o < CW'(RD_DEPTH) || pop;
   mem_port_arb_core #(.N(N), .ARB_MODE(ARB_MODE)) u_rd (
      .clk(clk), .rst_n(rst_n), .req(rd_req_i & {N{allow}}), .gnt(rd_gnt_o), .idx(ridx), .any(mem_re_o));
   assign mem_raddr_o = mem_re_o ? rd_addr_i[ridx*ADDR_W +: ADDR_W] : '0;
   assign rd_valid_o  = N'(pop) << tag[rp];
   assign rd_data_o   = pop ? mem_rdata_i : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp               <= '0;
         rp               <= '0;
         rd_outstanding_o <= '0;
         rd_err_o         <= 1'b0;
      end else begin
         wp               <= !mem_re_o ? wp : (wp == AW'(RD_DEPTH-1) ? '0 : wp + AW'(1));
         rp               <= !pop ? rp : (rp == AW'(RD_DEPTH-1) ? '0 : rp + AW'(1));
         rd_outstanding_o <= rd_outstanding_o + CW'(mem_re_o) - CW'(pop);
         rd_err_o         <= rd_err_o || (mem_rvalid_i && rd_outstanding_o == '0);
      end
   always_ff @(posedge clk)
      if (mem_re_o) tag[wp] <= ridx;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised, request-driven arbiter that shares one memory write port and one memory read port among N switch ports. It sits between the per-port memory write/read controllers and the packet buffer memory. It supports either fixed time-division slots or work-conserving round-robin. Read returns are routed back to the issuing port through an in-order port-ID tag FIFO, which bounds the number of outstanding reads.

## Interface
- N, 4: number of ports (≥2)
- ADDR_W, 10: block address width
- BLOCK_BITS, 512: memory block width
- RD_DEPTH, 4: max outstanding reads (tag FIFO depth, ≥1)
- ARB_MODE, 1: 0 = TDM slot, 1 = work-conserving round-robin

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_req_i  in  N  per-port write request
- wr_addr_i  in  N×ADDR_W  per-port write address
- wr_data_i  in  N×BLOCK_BITS  per-port write data
- wr_gnt_o  out  N  one-hot write grant; the write is accepted this cycle
- mem_we_o, mem_waddr_o, mem_wdata_o  out  1/ADDR_W/BLOCK_BITS  memory write port
- rd_req_i  in  N  per-port read request
- rd_addr_i  in  N×ADDR_W  per-port read address
- rd_gnt_o  out  N  one-hot read grant; the read is issued this cycle
- mem_re_o, mem_raddr_o  out  1/ADDR_W  memory read port
- mem_rvalid_i  in  1  memory read data valid; data returns in issue order
- mem_rdata_i  in  BLOCK_BITS  memory read data
- rd_valid_o  out  N  one-hot read-return valid
- rd_data_o  out  BLOCK_BITS  read data, broadcast to all ports
- rd_outstanding_o  out  $clog2(RD_DEPTH+1)  tag FIFO occupancy
- rd_err_o  out  1  sticky flag: rvalid received with no read outstanding

## Operation
- **Write and read arbiters:** independent; identical policy, each with its own state.
- **ARB_MODE=1 (round-robin):**
  - Pointer ptr (log2 N bits).
  - The grant goes to the first requester at or after ptr, wrapping modulo N.
  - On a grant to port k, ptr <= (k+1) mod N. With no grant, ptr holds.
- **ARB_MODE=0 (TDM):**
  - Slot counter increments every cycle and wraps N-1 -> 0.
  - The slot port is granted only if it is requesting; otherwise the cycle is idle.
- **Requester rule:** a requester holds req/addr/data stable until it sees a grant. A grant means the transaction was accepted in that cycle.
- **Write port:**
  - mem_we_o = |wr_gnt_o.
  - Address and data are muxed from the granted port; they are 0 when there is no grant.
- **Read issue:**
  - A read is allowed when rd_outstanding_o < RD_DEPTH, or when a pop happens in the same cycle (mem_rvalid_i && rd_outstanding_o != 0).
  - When not allowed: no rd_gnt_o, mem_re_o = 0, and the read pointer/slot logic behaves as if there were no grant. The TDM slot still advances.
  - On issue, the granted port ID is pushed into the tag FIFO.
- **Read return:**
  - On mem_rvalid_i with a non-empty FIFO: pop the head ID h, assert rd_valid_o[h], and set rd_data_o = mem_rdata_i.
  - On mem_rvalid_i with an empty FIFO: rd_valid_o = 0 and rd_err_o is set.
- **Simultaneous push and pop:** occupancy is unchanged, and FIFO ordering is preserved.
- **Occupancy arithmetic:** rd_outstanding_o += push − pop, saturating-free. Overflow and underflow are impossible by construction.

## Timing
- Grant and memory port outputs are combinational from the requests and current state: 0-cycle issue latency.
- rd_valid_o and rd_data_o are combinational from mem_rvalid_i, mem_rdata_i and the FIFO head: 0-cycle return routing.
- State updates (ptr, slot, FIFO, counter, rd_err_o) happen on posedge clk.
- Values after reset, while rst_n is asserted:
  - ptr = 0 and slot = 0.
  - FIFO empty, rd_outstanding_o = 0, rd_err_o = 0.
  - All grant and valid outputs are 0 when requests are 0.
- Reset mid-operation discards all outstanding tags. Returns that arrive after reset release set rd_err_o.

## Test plan
- **Round-robin fairness:** ARB_MODE=1, N=4, wr_req_i=4'b1111 held for 8 cycles -> grants to ports 0,1,2,3,0,1,2,3, with mem_waddr_o matching each port's address.
- **Work conservation:** ARB_MODE=1, only port 2 requests -> granted every cycle; then ports 1 and 3 request with ptr=3 -> grant 3, then 1.
- **TDM idle slots:** ARB_MODE=0, only port 1 requests -> granted on cycles 1, 5, 9 after reset; mem_we_o=0 on all other cycles.
- **Read routing:** reads issued by ports 3, 0, 2, with rvalid returned 2 cycles later in order -> rd_valid_o = 4'b1000, 4'b0001, 4'b0100, with data matching each return.
- **Full tag FIFO:** RD_DEPTH=4 with 4 reads outstanding and no rvalid -> rd_gnt_o=0 and mem_re_o=0. On the next cycle, rvalid plus a new request -> the issue is allowed and rd_outstanding_o stays at 4.
- **Error and reset:** rvalid with an empty FIFO -> rd_err_o=1 and stays set. Reset with 2 reads outstanding -> rd_outstanding_o=0 and rd_err_o=0.
